// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone SRAM responder.
// WB_SRAM_PARITY_EN widens the SRAM word to carry one even-parity bit per byte.
package wb_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_BURST,
    ST_WACK,
    ST_ERR,
    ST_TURN
  } state_e;

`ifdef WB_SRAM_PARITY_EN
  localparam int MEM_DW = 18;
`else
  localparam int MEM_DW = 16;
`endif

  localparam int BL4 = 4;
  localparam int BL8 = 8;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/wb_sram_burst_gen.sv
// Burst address generator: latches the first-beat address and burst length,
// then produces the wrapped address of the next beat to read and flags the final beat.
module wb_sram_burst_gen
  import wb_sram_pkg::*;
#(
  parameter int MEM_ADDR_W = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] start_addr,
  input  logic                  start_len8,
  input  logic                  advance,
  output logic [MEM_ADDR_W-1:0] next_addr,
  output logic                  last_beat
);

  logic [MEM_ADDR_W-1:0] base_q, base_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  len8_q, len8_d;
  logic [2:0]            mask;
  logic [2:0]            low;

  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    len8_d = len8_q;
    if (start) begin
      base_d = start_addr;
      cnt_d  = '0;
      len8_d = start_len8;
    end else if (advance) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // cnt_q is the beat being acknowledged; the address issued is for the beat after it.
  always_comb begin
    mask      = len8_q ? 3'(BL8 - 1) : 3'(BL4 - 1);
    low       = (base_q[2:0] + cnt_q + 3'd1) & mask;
    next_addr = {base_q[MEM_ADDR_W-1:3], (base_q[2:0] & ~mask) | low};
    last_beat = (cnt_q == mask);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      base_q <= '0;
      cnt_q  <= '0;
      len8_q <= 1'b0;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
      len8_q <= len8_d;
    end
  end

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone responder for a single-port synchronous SRAM: single reads/writes and 4/8-beat wrapped read bursts.
// Optional WB_SRAM_PARITY_EN stores per-byte parity and answers a corrupted read beat with wb_err.
module wb_sram_responder
  import wb_sram_pkg::*;
#(
  parameter int                   WB_ADDR_W  = 24,
  parameter int                   MEM_ADDR_W = 10,
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [WB_ADDR_W-1:0]  wb_adr,
  input  logic [15:0]           wb_i_dat,
  input  logic [1:0]            wb_sel,
  input  logic                  wb_4_burst,
  input  logic                  wb_8_burst,
  output logic [15:0]           wb_o_dat,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic                  wb_rty,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [1:0]            mem_wmask,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DW-1:0]     mem_wdata,
  input  logic [MEM_DW-1:0]     mem_rdata
);

  state_e                state_q, state_d;
  logic [15:0]           data_q, data_d;
  logic                  in_window;
  logic                  rd_perr;
  logic                  rd_ack;
  logic                  burst_start;
  logic                  burst_adv;
  logic [MEM_ADDR_W-1:0] burst_addr;
  logic                  burst_last;

  assign in_window = (wb_adr[WB_ADDR_W-1:MEM_ADDR_W] == BASE_ADDR[WB_ADDR_W-1:MEM_ADDR_W]);
  assign wb_rty    = 1'b0;
  assign mem_wmask = wb_sel;

`ifdef WB_SRAM_PARITY_EN
  assign mem_wdata = {wb_sel[1] & byte_parity(wb_i_dat[15:8]),
                      wb_sel[0] & byte_parity(wb_i_dat[7:0]), wb_i_dat};
  assign rd_perr   = (byte_parity(mem_rdata[15:8]) != mem_rdata[17]) ||
                     (byte_parity(mem_rdata[7:0])  != mem_rdata[16]);
`else
  assign mem_wdata = wb_i_dat;
  assign rd_perr   = 1'b0;
`endif

  wb_sram_burst_gen #(.MEM_ADDR_W(MEM_ADDR_W)) u_burst_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .start      (burst_start),
    .start_addr (wb_adr[MEM_ADDR_W-1:0]),
    .start_len8 (wb_8_burst),
    .advance    (burst_adv),
    .next_addr  (burst_addr),
    .last_beat  (burst_last)
  );

  // The first SRAM access is issued straight from IDLE so a single beat acks one cycle after the request.
  always_comb begin
    state_d     = state_q;
    wb_ack      = 1'b0;
    wb_err      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    rd_ack      = 1'b0;
    burst_start = 1'b0;
    burst_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rst && wb_cyc && wb_stb) begin
          if (!in_window) begin
            state_d = ST_ERR;
          end else begin
            mem_en   = 1'b1;
            mem_addr = wb_adr[MEM_ADDR_W-1:0];
            if (wb_we) begin
              mem_we  = 1'b1;
              state_d = ST_WACK;
            end else if (wb_4_burst || wb_8_burst) begin
              burst_start = 1'b1;
              state_d     = ST_BURST;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        if (!wb_cyc) begin
          state_d = ST_IDLE;
        end else begin
          wb_err  = rd_perr;
          wb_ack  = !rd_perr;
          rd_ack  = !rd_perr;
          state_d = ST_TURN;
        end
      end
      ST_BURST: begin
        if (!wb_cyc) begin
          state_d = ST_IDLE;
        end else if (rd_perr) begin
          wb_err  = 1'b1;
          state_d = ST_TURN;
        end else begin
          wb_ack = 1'b1;
          rd_ack = 1'b1;
          if (burst_last) begin
            state_d = ST_TURN;
          end else begin
            mem_en    = 1'b1;
            mem_addr  = burst_addr;
            burst_adv = 1'b1;
          end
        end
      end
      ST_WACK: begin
        if (!wb_cyc) begin
          state_d = ST_IDLE;
        end else begin
          wb_ack  = 1'b1;
          state_d = ST_TURN;
        end
      end
      ST_ERR: begin
        wb_err  = 1'b1;
        state_d = ST_TURN;
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_d   = rd_ack ? mem_rdata[15:0] : data_q;
  assign wb_o_dat = data_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule
